// File: rtl/csr_master_agent.sv
// CSR transaction master: runs one read/write command at a time on the CSR
// request/response channel, with a local timeout, plus a CAI doorbell monitor.
module csr_master_agent #(
   parameter int ADDR_W  = 12,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [31:0]       cmd_wdata,
   input  logic [3:0]        cmd_wstrb,
   input  logic [1:0]        cmd_priv,

   output logic              res_valid,
   output logic [31:0]       res_rdata,
   output logic              res_fault,

   output logic              csr_req_valid,
   input  logic              csr_req_ready,
   output logic              csr_req_write,
   output logic [ADDR_W-1:0] csr_req_addr,
   output logic [31:0]       csr_req_wdata,
   output logic [3:0]        csr_req_wstrb,
   output logic [1:0]        csr_req_priv,

   input  logic              csr_rsp_valid,
   output logic              csr_rsp_ready,
   input  logic [31:0]       csr_rsp_rdata,
   input  logic              csr_rsp_fault,

   input  logic              cai_submit_doorbell,
   input  logic [31:0]       cai_submit_ring_mask,
   output logic              cai_submit_seen,
   output logic [15:0]       cai_doorbell_count,
   output logic [31:0]       cai_ring_mask_q
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_RSP  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam int              CNT_W       = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT);

   logic [1:0]        state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [31:0]       rdata_reg, rdata_next;
   logic              fault_reg, fault_next;
   logic              cmd_take;
   logic              timeout_hit;

   logic              write_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [31:0]       wdata_reg;
   logic [3:0]        wstrb_reg;
   logic [1:0]        priv_reg;

   logic              seen_reg;
   logic [15:0]       count_reg;
   logic [31:0]       mask_reg;

   // The counter runs through both REQ and RSP, so a stalled request and a
   // missing response share one budget measured from REQ entry.
   assign timeout_hit = ((state_reg == S_REQ) || (state_reg == S_RSP)) &&
                        (cnt_reg == TIMEOUT_VAL);

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      rdata_next = rdata_reg;
      fault_next = fault_reg;
      cmd_take   = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (cmd_valid) begin
               cmd_take = 1'b1;
               cnt_next = '0;
               if (cmd_write && (cmd_wstrb == 4'h0)) begin
                  state_next = S_DONE;
                  fault_next = 1'b1;
                  rdata_next = 32'h0;
               end else begin
                  state_next = S_REQ;
               end
            end
         end
         S_REQ: begin
            cnt_next = cnt_reg + CNT_W'(1);
            if (timeout_hit) begin
               state_next = S_DONE;
               fault_next = 1'b1;
               rdata_next = 32'h0;
            end else if (csr_req_ready) begin
               state_next = S_RSP;
            end
         end
         S_RSP: begin
            cnt_next = cnt_reg + CNT_W'(1);
            if (timeout_hit) begin
               state_next = S_DONE;
               fault_next = 1'b1;
               rdata_next = 32'h0;
            end else if (csr_rsp_valid) begin
               state_next = S_DONE;
               fault_next = csr_rsp_fault;
               rdata_next = (write_reg || csr_rsp_fault) ? 32'h0 : csr_rsp_rdata;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_IDLE;
         cnt_reg   <= '0;
         rdata_reg <= 32'h0;
         fault_reg <= 1'b0;
         write_reg <= 1'b0;
         addr_reg  <= '0;
         wdata_reg <= 32'h0;
         wstrb_reg <= 4'h0;
         priv_reg  <= 2'b00;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         rdata_reg <= rdata_next;
         fault_reg <= fault_next;
         if (cmd_take) begin
            write_reg <= cmd_write;
            addr_reg  <= cmd_addr;
            wdata_reg <= cmd_wdata;
            wstrb_reg <= cmd_wstrb;
            priv_reg  <= cmd_priv;
         end
      end
   end

   // Doorbell monitor is independent of the command FSM.
   always_ff @(posedge clk) begin
      if (rst) begin
         seen_reg  <= 1'b0;
         count_reg <= 16'h0;
         mask_reg  <= 32'h0;
      end else if (cai_submit_doorbell) begin
         seen_reg <= 1'b1;
         if (count_reg != 16'hFFFF) begin
            count_reg <= count_reg + 16'h1;
         end
         mask_reg <= cai_submit_ring_mask;
      end
   end

   assign cmd_ready     = (state_reg == S_IDLE);
   assign csr_req_valid = (state_reg == S_REQ) && !timeout_hit;
   assign csr_rsp_ready = (state_reg == S_RSP) && !timeout_hit;
   assign csr_req_write = write_reg;
   assign csr_req_addr  = addr_reg;
   assign csr_req_wdata = wdata_reg;
   assign csr_req_wstrb = wstrb_reg;
   assign csr_req_priv  = priv_reg;

   assign res_valid = (state_reg == S_DONE);
   assign res_rdata = rdata_reg;
   assign res_fault = fault_reg;

   assign cai_submit_seen    = seen_reg;
   assign cai_doorbell_count = count_reg;
   assign cai_ring_mask_q    = mask_reg;

endmodule

// File: tb/tb_csr_master_agent.sv
// Directed self-checking bench for csr_master_agent (TIMEOUT overridden to 16).
module tb_csr_master_agent;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [11:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic [1:0]  cmd_priv;
   logic        res_valid, res_fault;
   logic [31:0] res_rdata;
   logic        csr_req_valid, csr_req_ready, csr_req_write;
   logic [11:0] csr_req_addr;
   logic [31:0] csr_req_wdata;
   logic [3:0]  csr_req_wstrb;
   logic [1:0]  csr_req_priv;
   logic        csr_rsp_valid, csr_rsp_ready, csr_rsp_fault;
   logic [31:0] csr_rsp_rdata;
   logic        cai_submit_doorbell, cai_submit_seen;
   logic [31:0] cai_submit_ring_mask, cai_ring_mask_q;
   logic [15:0] cai_doorbell_count;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   csr_master_agent #(.ADDR_W(12), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_priv(cmd_priv),
      .res_valid(res_valid), .res_rdata(res_rdata), .res_fault(res_fault),
      .csr_req_valid(csr_req_valid), .csr_req_ready(csr_req_ready),
      .csr_req_write(csr_req_write), .csr_req_addr(csr_req_addr),
      .csr_req_wdata(csr_req_wdata), .csr_req_wstrb(csr_req_wstrb), .csr_req_priv(csr_req_priv),
      .csr_rsp_valid(csr_rsp_valid), .csr_rsp_ready(csr_rsp_ready),
      .csr_rsp_rdata(csr_rsp_rdata), .csr_rsp_fault(csr_rsp_fault),
      .cai_submit_doorbell(cai_submit_doorbell), .cai_submit_ring_mask(cai_submit_ring_mask),
      .cai_submit_seen(cai_submit_seen), .cai_doorbell_count(cai_doorbell_count),
      .cai_ring_mask_q(cai_ring_mask_q)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic issue(input logic w, input logic [11:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [1:0] p);
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      cmd_wstrb = s;
      cmd_priv  = p;
   endtask

   // Zero-wait slave read; the bench expects rdata forced to 0 on a slave fault.
   task automatic zw_read(input string tag, input logic [11:0] a, input logic [31:0] d,
                          input logic f);
      csr_req_ready = 1'b1;
      csr_rsp_valid = 1'b1;
      csr_rsp_rdata = d;
      csr_rsp_fault = f;
      issue(1'b0, a, 32'h0, 4'hF, 2'd1);
      chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
      cyc();
      cmd_valid = 1'b0;
      cyc();
      cyc();
      chk({tag, "_res_valid"}, 32'(res_valid), 32'd1);
      chk({tag, "_res_rdata"}, res_rdata, f ? 32'h0 : d);
      chk({tag, "_res_fault"}, 32'(res_fault), 32'(f));
      csr_rsp_valid = 1'b0;
      csr_rsp_fault = 1'b0;
      csr_req_ready = 1'b0;
      cyc();
      $display("txn %s addr=%h rdata=%h fault=%0d", tag, a, res_rdata, res_fault);
   endtask

   initial begin
      rst = 1'b1;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 12'h0; cmd_wdata = 32'h0;
      cmd_wstrb = 4'h0; cmd_priv = 2'd0;
      csr_req_ready = 1'b0; csr_rsp_valid = 1'b0; csr_rsp_rdata = 32'h0; csr_rsp_fault = 1'b0;
      cai_submit_doorbell = 1'b1; cai_submit_ring_mask = 32'hA5A5A5A5;

      // Reset, with a doorbell held high the whole time (reset must win).
      cyc();
      cyc();
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res_rdata", res_rdata, 32'h0);
      chk("rst_res_fault", 32'(res_fault), 32'd0);
      chk("rst_req_valid", 32'(csr_req_valid), 32'd0);
      chk("rst_req_addr", 32'(csr_req_addr), 32'd0);
      chk("rst_rsp_ready", 32'(csr_rsp_ready), 32'd0);
      chk("rst_seen", 32'(cai_submit_seen), 32'd0);
      chk("rst_db_count", 32'(cai_doorbell_count), 32'd0);
      chk("rst_mask", cai_ring_mask_q, 32'h0);
      rst = 1'b0;
      cai_submit_doorbell = 1'b0;
      cai_submit_ring_mask = 32'h0;
      cyc();
      $display("txn reset done");

      // Write MODEFLAGS, zero-wait slave: res_valid 3 cycles after accept.
      csr_req_ready = 1'b1; csr_rsp_valid = 1'b1; csr_rsp_rdata = 32'h12345678; csr_rsp_fault = 1'b0;
      issue(1'b1, 12'h010, 32'h00000000, 4'hF, 2'd1);
      chk("wr_cmd_ready", 32'(cmd_ready), 32'd1);
      cyc();
      cmd_valid = 1'b0;
      chk("wr_req_valid", 32'(csr_req_valid), 32'd1);
      chk("wr_req_write", 32'(csr_req_write), 32'd1);
      chk("wr_req_addr", 32'(csr_req_addr), 32'h010);
      chk("wr_req_wdata", csr_req_wdata, 32'h0);
      chk("wr_req_wstrb", 32'(csr_req_wstrb), 32'hF);
      chk("wr_req_priv", 32'(csr_req_priv), 32'd1);
      chk("wr_busy", 32'(cmd_ready), 32'd0);
      cyc();
      chk("wr_rsp_ready", 32'(csr_rsp_ready), 32'd1);
      chk("wr_req_dropped", 32'(csr_req_valid), 32'd0);
      chk("wr_no_early_res", 32'(res_valid), 32'd0);
      cyc();
      chk("wr_res_valid", 32'(res_valid), 32'd1);
      chk("wr_res_fault", 32'(res_fault), 32'd0);
      chk("wr_res_rdata", res_rdata, 32'h0);
      csr_req_ready = 1'b0; csr_rsp_valid = 1'b0;
      cyc();
      chk("wr_res_pulse", 32'(res_valid), 32'd0);
      chk("wr_idle", 32'(cmd_ready), 32'd1);
      $display("txn write MODEFLAGS fault=%0d rdata=%h", res_fault, res_rdata);

      // Read TIER, 5 wait cycles on the request; a stray response in REQ is ignored.
      issue(1'b0, 12'h020, 32'hFFFFFFFF, 4'h0, 2'd1);
      cyc();
      cmd_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("rd_req_held", 32'(csr_req_valid), 32'd1);
         chk("rd_req_addr", 32'(csr_req_addr), 32'h020);
         csr_rsp_valid = (i == 2);
         csr_rsp_rdata = 32'hAAAAAAAA;
         cyc();
      end
      csr_rsp_valid = 1'b0;
      chk("rd_req_held_last", 32'(csr_req_valid), 32'd1);
      chk("rd_req_write", 32'(csr_req_write), 32'd0);
      csr_req_ready = 1'b1;
      cyc();
      chk("rd_rsp_ready", 32'(csr_rsp_ready), 32'd1);
      csr_req_ready = 1'b0;
      csr_rsp_valid = 1'b1; csr_rsp_rdata = 32'h00000000; csr_rsp_fault = 1'b0;
      cyc();
      chk("rd_res_valid", 32'(res_valid), 32'd1);
      chk("rd_res_rdata", res_rdata, 32'h0);
      chk("rd_res_fault", 32'(res_fault), 32'd0);
      csr_rsp_valid = 1'b0;
      cyc();
      $display("txn read TIER rdata=%h fault=%0d", res_rdata, res_fault);

      // Slave fault, then a clean read, then a write with no strobes.
      zw_read("slvfault", 12'h024, 32'hDEADBEEF, 1'b1);
      zw_read("rd_data", 12'h028, 32'h1234ABCD, 1'b0);
      issue(1'b1, 12'h030, 32'h11111111, 4'h0, 2'd3);
      csr_req_ready = 1'b1;
      cyc();
      cmd_valid = 1'b0;
      chk("strb_res_valid", 32'(res_valid), 32'd1);
      chk("strb_res_fault", 32'(res_fault), 32'd1);
      chk("strb_res_rdata", res_rdata, 32'h0);
      chk("strb_no_req", 32'(csr_req_valid), 32'd0);
      cyc();
      chk("strb_no_req_after", 32'(csr_req_valid), 32'd0);
      chk("strb_idle", 32'(cmd_ready), 32'd1);
      csr_req_ready = 1'b0;
      $display("txn write wstrb=0 fault=%0d", res_fault);

      // Timeout with request accepted but no response.
      zw_read("pre_to", 12'h034, 32'h00000055, 1'b0);
      csr_req_ready = 1'b1;
      issue(1'b0, 12'h040, 32'h0, 4'hF, 2'd0);
      cyc();
      cmd_valid = 1'b0;
      for (int k = 0; k <= 16; k++) begin
         chk("to_rsp_no_res", 32'(res_valid), 32'd0);
         if (k == 15) chk("to_rsp_ready_before", 32'(csr_rsp_ready), 32'd1);
         if (k == 16) chk("to_rsp_ready_drop", 32'(csr_rsp_ready), 32'd0);
         cyc();
      end
      chk("to_rsp_res_valid", 32'(res_valid), 32'd1);
      chk("to_rsp_res_fault", 32'(res_fault), 32'd1);
      chk("to_rsp_res_rdata", res_rdata, 32'h0);
      csr_req_ready = 1'b0;
      cyc();
      chk("to_rsp_idle", 32'(cmd_ready), 32'd1);
      $display("txn timeout (no response) fault=%0d", res_fault);

      // Timeout with the request never accepted.
      issue(1'b1, 12'h050, 32'h00000001, 4'h1, 2'd2);
      cyc();
      cmd_valid = 1'b0;
      for (int k = 0; k <= 16; k++) begin
         chk("to_req_valid", 32'(csr_req_valid), (k < 16) ? 32'd1 : 32'd0);
         cyc();
      end
      chk("to_req_res_valid", 32'(res_valid), 32'd1);
      chk("to_req_res_fault", 32'(res_fault), 32'd1);
      cyc();
      $display("txn timeout (no accept) fault=%0d", res_fault);

      // Doorbell monitor.
      cai_submit_doorbell = 1'b1; cai_submit_ring_mask = 32'h000000FF;
      cyc();
      cai_submit_doorbell = 1'b0; cai_submit_ring_mask = 32'hDEAD0000;
      chk("db_seen", 32'(cai_submit_seen), 32'd1);
      chk("db_count1", 32'(cai_doorbell_count), 32'd1);
      chk("db_mask1", cai_ring_mask_q, 32'h000000FF);
      cyc();
      chk("db_mask_hold", cai_ring_mask_q, 32'h000000FF);
      for (int p = 0; p < 2; p++) begin
         cai_submit_doorbell = 1'b1; cai_submit_ring_mask = 32'h000000FF;
         cyc();
         cai_submit_doorbell = 1'b0; cai_submit_ring_mask = 32'h0;
         cyc();
      end
      chk("db_count3", 32'(cai_doorbell_count), 32'd3);
      chk("db_mask3", cai_ring_mask_q, 32'h000000FF);
      chk("db_seen3", 32'(cai_submit_seen), 32'd1);
      $display("txn doorbells count=%0d mask=%h", cai_doorbell_count, cai_ring_mask_q);

      // Reset while in RSP aborts the command; the next one completes.
      zw_read("pre_rst", 12'h070, 32'hCAFEF00D, 1'b0);
      csr_req_ready = 1'b1; csr_rsp_valid = 1'b0;
      issue(1'b0, 12'h060, 32'h0, 4'hF, 2'd1);
      cyc();
      cmd_valid = 1'b0;
      cyc();
      chk("mrst_in_rsp", 32'(csr_rsp_ready), 32'd1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("mrst_rsp_ready", 32'(csr_rsp_ready), 32'd0);
      chk("mrst_req_valid", 32'(csr_req_valid), 32'd0);
      chk("mrst_req_addr", 32'(csr_req_addr), 32'd0);
      chk("mrst_res_valid", 32'(res_valid), 32'd0);
      chk("mrst_res_rdata", res_rdata, 32'h0);
      chk("mrst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("mrst_db_count", 32'(cai_doorbell_count), 32'd0);
      chk("mrst_seen", 32'(cai_submit_seen), 32'd0);
      csr_req_ready = 1'b0;
      cyc();
      chk("mrst_no_res", 32'(res_valid), 32'd0);
      $display("txn reset in RSP aborted");
      zw_read("post_rst", 12'h080, 32'h00C0FFEE, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
